// File: rtl/instruction_sequencer_pkg.sv
// instruction_sequencer_pkg: opcodes, FSM encoding and flag indices shared by the sequencer and its ALU
package instruction_sequencer_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JEQ  = 4'h9;
  localparam logic [3:0] OP_JGT  = 4'hA;
  localparam logic [3:0] OP_JLT  = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam int F_LESS    = 4;
  localparam int F_GREATER = 3;
  localparam int F_EQUAL   = 2;
  localparam int F_CARRY   = 1;
  localparam int F_BORROW  = 0;
  function automatic logic is_alu_op(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_CMP;
  endfunction
endpackage

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/execute FSM driving an external multi-cycle ALU
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int         ALU_LAT  = 2,
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       imem_req,
  output logic [3:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic       imem_valid,
  output logic [3:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_result,
  input  logic [4:0] alu_flag,
  output logic [3:0] acc,
  output logic [4:0] flags_q,
  output logic       busy,
  output logic       halted
);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);
  logic [2:0] state;
  logic [3:0] pc, op, imm;
  logic [CW-1:0] cnt;
  logic in_exec, jump;
  // ALU drive is decoded from state so reset clears it in the same cycle
  assign in_exec    = state == S_EXEC;
  assign alu_opcode = in_exec ? op : 4'h0;
  assign alu_a      = in_exec ? acc : 4'h0;
  assign alu_b      = in_exec ? imm : 4'h0;
  assign imem_req   = state == S_FETCH;
  assign imem_addr  = pc;
  assign busy       = !(state == S_IDLE || state == S_HALT);
  assign halted     = state == S_HALT;
  assign jump = op == OP_JMP ||
                (op == OP_JEQ && flags_q[F_EQUAL]) ||
                (op == OP_JGT && flags_q[F_GREATER]) ||
                (op == OP_JLT && flags_q[F_LESS]) ||
                (op == OP_JC  && flags_q[F_CARRY]);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      acc     <= 4'h0;
      flags_q <= 5'h0;
      op      <= OP_NOP;
      imm     <= 4'h0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) begin
          state <= S_FETCH;
          pc    <= RESET_PC;
          acc   <= 4'h0;
        end
        S_FETCH: if (imem_valid) begin
          op    <= imem_data[7:4];
          imm   <= imem_data[3:0];
          state <= S_DECODE;
        end
        S_DECODE: begin
          state <= is_alu_op(op) ? S_EXEC : S_WB;
          cnt   <= '0;
        end
        // the result is sampled on the edge that ends the ALU_LAT-th EXEC cycle
        S_EXEC: if (cnt == CNT_LAST) begin
          state   <= S_WB;
          acc     <= op == OP_CMP ? acc : alu_result;
          flags_q <= alu_flag;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_WB: begin
          state <= op == OP_HALT ? S_HALT : S_FETCH;
          pc    <= jump ? imm : pc + 4'h1;
          if (op == OP_LDI) acc <= imm;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: scoreboard bench with an instruction-level reference model and a latency-aware ALU
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;
  localparam int ALU_LAT = 2;
  localparam logic [3:0] RESET_PC = 4'h0;
  logic clk = 0, reset = 1, start = 0;
  logic imem_req, imem_valid, busy, halted;
  logic [3:0] imem_addr, alu_opcode, alu_a, alu_b, alu_result, acc;
  logic [7:0] imem_data;
  logic [4:0] alu_flag, flags_q;
  instruction_sequencer #(.ALU_LAT(ALU_LAT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_flag(alu_flag),
    .acc(acc), .flags_q(flags_q), .busy(busy), .halted(halted)
  );
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    logic [3:0] r;
    logic c, bw;
    sum = {1'b0, a} + {1'b0, b};
    r = op == OP_ADD ? sum[3:0] : op == OP_AND ? (a & b) : op == OP_OR ? (a | b) :
        op == OP_XOR ? (a ^ b) : a - b;
    c = op == OP_ADD && sum[4];
    bw = (op == OP_SUB || op == OP_CMP) && a < b;
    return {a < b, a > b, a == b, c, bw, r};
  endfunction

  // instruction memory: response after mem_wait cycles of request, noise on valid when idle
  logic [7:0] prog [16];
  int mem_wait = 1, wcnt = 0;
  logic noise = 0;
  always @(posedge clk) wcnt <= (imem_req && !imem_valid) ? wcnt + 1 : 0;
  always @(negedge clk) noise <= 1'($urandom);
  assign imem_valid = imem_req ? (wcnt >= mem_wait) : noise;
  assign imem_data  = imem_req ? prog[imem_addr] : 8'hF0;

  // ALU: output is corrupted until operands have been held for ALU_LAT cycles
  int age = 0;
  logic [8:0] alu_out;
  always @(posedge clk) age <= (alu_opcode != 4'h0) ? age + 1 : 0;
  assign alu_out    = alu_f(alu_opcode, alu_a, alu_b);
  assign alu_result = (age >= ALU_LAT - 1) ? alu_out[3:0] : ~alu_out[3:0];
  assign alu_flag   = (age >= ALU_LAT - 1) ? alu_out[8:4] : ~alu_out[8:4];

  logic [3:0]  exp_addr[$];
  int          exp_gap[$];
  logic [11:0] exp_alu[$];
  logic [8:0]  exp_final[$];
  logic [4:0]  m_flags = 5'h0;

  task automatic flush();
    exp_addr.delete(); exp_gap.delete(); exp_alu.delete(); exp_final.delete();
  endtask

  task automatic model_run();
    logic [3:0] pc, a, op, imm;
    logic [8:0] r;
    int prev_cost;
    pc = RESET_PC; a = 4'h0; prev_cost = 0;
    for (int n = 0; n < 64; n++) begin
      exp_addr.push_back(pc);
      exp_gap.push_back(prev_cost);
      op = prog[pc][7:4];
      imm = prog[pc][3:0];
      if (op >= OP_ADD && op <= OP_CMP) begin
        exp_alu.push_back({op, a, imm});
        r = alu_f(op, a, imm);
        if (op != OP_CMP) a = r[3:0];
        m_flags = r[8:4];
        prev_cost = ALU_LAT + 3 + mem_wait;
        pc = pc + 4'h1;
      end else begin
        prev_cost = 3 + mem_wait;
        if (op == OP_HALT) begin
          exp_final.push_back({m_flags, a});
          return;
        end
        if (op == OP_LDI) a = imm;
        if (op == OP_JMP || (op == OP_JEQ && m_flags[2]) || (op == OP_JGT && m_flags[3]) ||
            (op == OP_JLT && m_flags[4]) || (op == OP_JC && m_flags[1])) pc = imm;
        else pc = pc + 4'h1;
      end
    end
    miscompares++;
    $display("FAIL model: program never halts");
  endtask

  // monitor
  int cyc = 0, last_fetch = 0, exec_len = 0, eg;
  logic prev_req = 0, prev_halted = 0;
  logic [3:0] hold_addr;
  logic [11:0] cur_alu;
  logic [8:0] fin;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      prev_req = 0; prev_halted = 0; exec_len = 0;
    end else begin
      if (imem_req) begin
        if (prev_req) chk("fetch_addr_stable", imem_addr, hold_addr);
        else hold_addr = imem_addr;
        if (imem_valid) begin
          if (exp_addr.size() == 0) chk("unexpected_fetch", imem_addr, 32'hFFFF);
          else begin
            chk("fetch_addr", imem_addr, exp_addr.pop_front());
            eg = exp_gap.pop_front();
            if (eg != 0) chk("instr_cycles", cyc - last_fetch, eg);
          end
          last_fetch = cyc;
        end
      end
      prev_req = imem_req;
      if (alu_opcode != 4'h0) begin
        if (exec_len == 0) begin
          if (exp_alu.size() == 0) begin
            chk("unexpected_alu_op", alu_opcode, 0);
            cur_alu = 12'h0;
          end else cur_alu = exp_alu.pop_front();
        end
        chk("alu_drive", {alu_opcode, alu_a, alu_b}, cur_alu);
        exec_len++;
      end else if (exec_len != 0) begin
        chk("exec_len", exec_len, ALU_LAT);
        exec_len = 0;
      end
      if (halted && !prev_halted) begin
        if (exp_final.size() == 0) chk("unexpected_halt", 1, 0);
        else begin
          fin = exp_final.pop_front();
          chk("final_acc", acc, fin[3:0]);
          chk("final_flags", flags_q, fin[8:4]);
        end
      end
      prev_halted = halted;
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
    chk({tag, "_alu"}, {alu_opcode, alu_a, alu_b}, 0);
    chk({tag, "_acc"}, acc, 0);
    chk({tag, "_flags"}, flags_q, 0);
    chk({tag, "_busy_halted"}, {busy, halted}, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic run_prog(input int w, input bit poke);
    mem_wait = w;
    model_run();
    pulse_start();
    if (poke) begin
      repeat (4) @(negedge clk);
      if (busy) begin
        start = 1; @(negedge clk); start = 0;
      end
    end
    for (int i = 0; i < 800 && !halted; i++) @(negedge clk);
    if (!halted) begin
      chk("halt_timeout", halted, 1);
      flush();
    end
    @(negedge clk);
    chk("queues_drained", exp_addr.size() + exp_alu.size() + exp_final.size(), 0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic prog_add();
    clear_prog();
    prog[0] = 8'h73; prog[1] = 8'h14; prog[2] = 8'hF0;
  endtask

  initial begin
    clear_prog();
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 0;
    // LDI 3, ADD 4, HALT
    prog_add();
    run_prog(1, 0);
    chk("add_acc", acc, 7);
    chk("add_halted", halted, 1);
    // compare and taken branch
    clear_prog();
    prog[0] = 8'h75; prog[1] = 8'h65; prog[2] = 8'h96; prog[3] = 8'hF0;
    prog[4] = 8'hF0; prog[5] = 8'hF0; prog[6] = 8'h79; prog[7] = 8'hF0;
    run_prog(1, 0);
    chk("jeq_acc", acc, 9);
    chk("jeq_equal_flag", flags_q[2], 1);
    // carry out of ADD, then JC back to address 0
    clear_prog();
    prog[0] = 8'hC5; prog[1] = 8'h7F; prog[2] = 8'h11; prog[3] = 8'hC0; prog[5] = 8'hF0;
    run_prog(1, 0);
    chk("carry_acc", acc, 0);
    chk("carry_flag", flags_q[1], 1);
    // slow memory
    prog_add();
    run_prog(4, 0);
    chk("slow_mem_acc", acc, 7);
    // pc wrap from F to 0, with a start pulse while busy
    clear_prog();
    prog[0] = 8'hC2; prog[1] = 8'h83; prog[2] = 8'hF0; prog[14] = 8'h7F; prog[15] = 8'h11;
    run_prog(1, 1);
    chk("wrap_acc", acc, 0);
    // reset in the middle of EXEC
    prog_add();
    mem_wait = 1;
    model_run();
    pulse_start();
    for (int i = 0; i < 50 && alu_opcode == 4'h0; i++) @(negedge clk);
    chk("reached_exec", alu_opcode, OP_ADD);
    #2 reset = 1;
    #1 check_idle("mid_exec_reset");
    flush();
    m_flags = 5'h0;
    @(negedge clk);
    reset = 0;
    run_prog(1, 0);
    chk("rerun_acc", acc, 7);
    // random forward-branching programs
    for (int t = 0; t < 40; t++) begin
      for (int a = 0; a < 15; a++) begin
        logic [3:0] op, imm;
        op = 4'($urandom_range(0, 15));
        imm = 4'($urandom_range(0, 15));
        if (op >= OP_JMP && op <= OP_JC) imm = 4'(a + 1 + $urandom_range(0, 14 - a));
        prog[a] = {op, imm};
      end
      prog[15] = 8'hF0;
      run_prog($urandom_range(1, 3), 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
